// File: rtl/cic_interp_out_scaler_pkg.sv
// Shared widths, constants and config helpers for the CIC interpolator output scaler.
package cic_interp_out_scaler_pkg;

    localparam int DIN_W    = 48;
    localparam int MID_W    = 25;
    localparam int GAIN_W   = 18;
    localparam int DOUT_W   = 18;
    localparam int SHIFT_W  = 6;
    localparam int PROD_W   = MID_W + GAIN_W;
    localparam int OUT_FRAC = 16;

    localparam logic [SHIFT_W-1:0]       SHIFT_MAX  = 6'd47;
    localparam logic signed [GAIN_W-1:0] GAIN_UNITY = 18'sh10000;

    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
        return (s > SHIFT_MAX) ? SHIFT_MAX : s;
    endfunction

endpackage

// File: rtl/cic_interp_out_scaler_if.sv
// Sample and configuration bus between the CIC integrator and the output scaler.
interface cic_interp_out_scaler_if;
    import cic_interp_out_scaler_pkg::*;

    // Valid-only handshake: dInValid/dOutValid qualify data on the same clk; there is
    // no ready, the pipe never stalls and every sample is accepted on the edge it is presented.
    logic signed [DIN_W-1:0]  dIn;
    logic                     dInValid;
    logic [SHIFT_W-1:0]       shiftIn;
    logic signed [GAIN_W-1:0] gainIn;
    logic                     cfgLoad;
    logic                     satClear;
    logic signed [DOUT_W-1:0] dOut;
    logic                     dOutValid;
    logic                     satFlag;

    modport master (
        output dIn, dInValid, shiftIn, gainIn, cfgLoad, satClear,
        input  dOut, dOutValid, satFlag
    );

    modport slave (
        input  dIn, dInValid, shiftIn, gainIn, cfgLoad, satClear,
        output dOut, dOutValid, satFlag
    );

endinterface

// File: rtl/cic_interp_out_scaler_sat_round.sv
// Combinational round-half-up arithmetic right shift followed by signed saturation.
module cic_interp_out_scaler_sat_round
    import cic_interp_out_scaler_pkg::*;
#(
    parameter int IN_W  = 48,
    parameter int OUT_W = 25,
    parameter int FRAC  = 0
) (
    input  logic signed [IN_W-1:0]  din,
    input  logic [SHIFT_W-1:0]      sh,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    localparam int EXT_W = IN_W + 1;

    logic [6:0]              eff;
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shd;
    logic [EXT_W-OUT_W:0]    hi;

    always_comb begin
        eff = 7'(FRAC) + 7'(sh);
        ext = {din[IN_W-1], din};
        rnd = '0;
        if (eff != 7'd0) begin
            rnd = EXT_W'(1) << (eff - 7'd1);
        end
        // One guard bit keeps the rounding add from wrapping at the top of the range.
        sum  = ext + rnd;
        shd  = sum >>> eff;
        hi   = shd[EXT_W-1:OUT_W-1];
        sat  = !((&hi) || !(|hi));
        dout = shd[OUT_W-1:0];
        if (sat) begin
            dout = shd[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/cic_interp_out_scaler.sv
// CIC interpolator output normaliser: shift, gain trim, round and saturate to 18 bits, 4-clk pipe.
module cic_interp_out_scaler
    import cic_interp_out_scaler_pkg::*;
(
    input logic                    clk,
    input logic                    reset,
    cic_interp_out_scaler_if.slave bus
);

    logic [SHIFT_W-1:0]       cfg_shift_q, cfg_shift_d;
    logic signed [GAIN_W-1:0] cfg_gain_q, cfg_gain_d;

    logic signed [DIN_W-1:0]  s1_data_q, s1_data_d;
    logic                     s1_valid_q, s1_valid_d;
    logic [SHIFT_W-1:0]       s1_shift_q, s1_shift_d;
    logic signed [GAIN_W-1:0] s1_gain_q, s1_gain_d;

    logic signed [MID_W-1:0]  s2_data_q, s2_data_d;
    logic                     s2_valid_q, s2_valid_d;
    logic                     s2_sat_q, s2_sat_d;
    logic signed [GAIN_W-1:0] s2_gain_q, s2_gain_d;

    logic signed [PROD_W-1:0] s3_prod_q, s3_prod_d;
    logic                     s3_valid_q, s3_valid_d;
    logic                     s3_sat_q, s3_sat_d;

    logic signed [DOUT_W-1:0] dout_q, dout_d;
    logic                     dout_valid_q, dout_valid_d;
    logic                     sat_flag_q, sat_flag_d;

    logic signed [MID_W-1:0]  mid_rnd;
    logic                     mid_sat;
    logic signed [DOUT_W-1:0] out_rnd;
    logic                     out_sat;

    cic_interp_out_scaler_sat_round #(
        .IN_W  (DIN_W),
        .OUT_W (MID_W),
        .FRAC  (0)
    ) u_mid_round (
        .din  (s1_data_q),
        .sh   (s1_shift_q),
        .dout (mid_rnd),
        .sat  (mid_sat)
    );

    cic_interp_out_scaler_sat_round #(
        .IN_W  (PROD_W),
        .OUT_W (DOUT_W),
        .FRAC  (OUT_FRAC)
    ) u_out_round (
        .din  (s3_prod_q),
        .sh   ('0),
        .dout (out_rnd),
        .sat  (out_sat)
    );

    always_comb begin
        cfg_shift_d = cfg_shift_q;
        cfg_gain_d  = cfg_gain_q;
        if (bus.cfgLoad) begin
            cfg_shift_d = clamp_shift(bus.shiftIn);
            cfg_gain_d  = bus.gainIn;
        end

        // Each sample snapshots the active config at capture, so in-flight samples keep their scale.
        s1_data_d  = bus.dIn;
        s1_valid_d = bus.dInValid;
        s1_shift_d = cfg_shift_q;
        s1_gain_d  = cfg_gain_q;

        s2_data_d  = mid_rnd;
        s2_sat_d   = mid_sat;
        s2_valid_d = s1_valid_q;
        s2_gain_d  = s1_gain_q;

        s3_prod_d  = PROD_W'(s2_data_q) * PROD_W'(s2_gain_q);
        s3_sat_d   = s2_sat_q;
        s3_valid_d = s2_valid_q;

        dout_d       = out_rnd;
        dout_valid_d = s3_valid_q;

        sat_flag_d = sat_flag_q;
        if (s3_valid_q && (s3_sat_q || out_sat)) begin
            sat_flag_d = 1'b1;
        end else if (bus.satClear) begin
            sat_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_shift_q  <= '0;
            cfg_gain_q   <= GAIN_UNITY;
            s1_data_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_shift_q   <= '0;
            s1_gain_q    <= '0;
            s2_data_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_sat_q     <= 1'b0;
            s2_gain_q    <= '0;
            s3_prod_q    <= '0;
            s3_valid_q   <= 1'b0;
            s3_sat_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sat_flag_q   <= 1'b0;
        end else begin
            cfg_shift_q  <= cfg_shift_d;
            cfg_gain_q   <= cfg_gain_d;
            s1_data_q    <= s1_data_d;
            s1_valid_q   <= s1_valid_d;
            s1_shift_q   <= s1_shift_d;
            s1_gain_q    <= s1_gain_d;
            s2_data_q    <= s2_data_d;
            s2_valid_q   <= s2_valid_d;
            s2_sat_q     <= s2_sat_d;
            s2_gain_q    <= s2_gain_d;
            s3_prod_q    <= s3_prod_d;
            s3_valid_q   <= s3_valid_d;
            s3_sat_q     <= s3_sat_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sat_flag_q   <= sat_flag_d;
        end
    end

    assign bus.dOut      = dout_q;
    assign bus.dOutValid = dout_valid_q;
    assign bus.satFlag   = sat_flag_q;

endmodule

// File: tb/tb_cic_interp_out_scaler.sv
// Self-checking bench for cic_interp_out_scaler: vector table, corner sequences, random vs model.
module tb_cic_interp_out_scaler;

    typedef struct {
        logic [47:0]        din;
        logic [5:0]         sh;
        logic [17:0]        g;
        logic signed [17:0] exp_d;
        bit                 exp_sat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cic_interp_out_scaler_if bus();

    cic_interp_out_scaler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // {valid, sat, data} per captured sample; front entry is what leaves after the next edge.
    logic [19:0]        exp_q[$];
    logic signed [17:0] obs_q[$];
    logic signed [17:0] last_dout;
    logic [5:0]         m_shift;
    logic [17:0]        m_gain;
    bit                 m_flag;
    int                 n_in_valid;
    int                 n_out_valid;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [19:0] model(input logic [47:0] d, input logic [5:0] sh,
                                          input logic [17:0] g, input bit v);
        longint x, r, p, q, one;
        bit     s;
        one = 1;
        x = longint'($signed(d));
        r = x;
        if (sh != 0) r = (x + (one << (sh - 1))) >>> sh;
        s = 1'b0;
        if (r > 16777215)  begin r = 16777215;  s = 1'b1; end
        if (r < -16777216) begin r = -16777216; s = 1'b1; end
        p = r * longint'($signed(g));
        q = (p + 32768) >>> 16;
        if (q > 131071)  begin q = 131071;  s = 1'b1; end
        if (q < -131072) begin q = -131072; s = 1'b1; end
        return {v, s, 18'(q)};
    endfunction

    task automatic cycle(input logic [47:0] d, input bit v, input bit ld,
                         input logic [5:0] sh, input logic [17:0] g, input bit clr);
        logic [19:0]        e;
        logic signed [17:0] got;
        bus.dIn      = d;
        bus.dInValid = v;
        bus.cfgLoad  = ld;
        bus.shiftIn  = sh;
        bus.gainIn   = g;
        bus.satClear = clr;
        exp_q.push_back(model(d, m_shift, m_gain, v));
        if (v) n_in_valid++;
        if (ld) begin
            m_shift = (sh > 6'd47) ? 6'd47 : sh;
            m_gain  = g;
        end
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        if (e[19] && e[18]) m_flag = 1'b1;
        else if (clr) m_flag = 1'b0;
        check("dout_valid", longint'(bus.dOutValid), longint'(e[19]));
        if (e[19]) begin
            got = bus.dOut;
            check("dout", longint'(got), longint'($signed(e[17:0])));
            last_dout = got;
            obs_q.push_back(got);
        end
        if (bus.dOutValid) n_out_valid++;
        check("sat_flag", longint'(bus.satFlag), longint'(m_flag));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(48'd0, 1'b0, 1'b0, 6'd0, 18'd0, 1'b0);
    endtask

    task automatic load_cfg(input logic [5:0] sh, input logic [17:0] g, input bit clr);
        cycle(48'd0, 1'b0, 1'b1, sh, g, clr);
    endtask

    task automatic do_reset();
        bus.dIn      = '0;
        bus.dInValid = 1'b0;
        bus.cfgLoad  = 1'b0;
        bus.shiftIn  = '0;
        bus.gainIn   = '0;
        bus.satClear = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) exp_q.push_back(20'h0);
        m_shift = 6'd0;
        m_gain  = 18'h10000;
        m_flag  = 1'b0;
        check("reset_dout_valid", longint'(bus.dOutValid), 0);
        check("reset_dout", longint'(bus.dOut), 0);
        check("reset_sat_flag", longint'(bus.satFlag), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t               vecs[12];
        logic signed [17:0] prev;
        int                 n_old, n_new, n_bad, n_trans, tmp;
        logic [47:0]        d;
        logic [5:0]         rsh;
        logic [17:0]        rg;

        vecs[0]  = '{48'd1000,                    6'd0,  18'h10000, 18'sd1000,    1'b0};
        vecs[1]  = '{48'd24,                      6'd4,  18'h10000, 18'sd2,       1'b0};
        vecs[2]  = '{-48'sd24,                    6'd4,  18'h10000, -18'sd1,      1'b0};
        vecs[3]  = '{48'd23,                      6'd4,  18'h10000, 18'sd1,       1'b0};
        vecs[4]  = '{48'd8,                       6'd4,  18'h10000, 18'sd1,       1'b0};
        vecs[5]  = '{48'd1001,                    6'd0,  18'h08000, 18'sd501,     1'b0};
        vecs[6]  = '{-48'sd100,                   6'd0,  18'h18000, -18'sd150,    1'b0};
        vecs[7]  = '{48'd1073741824,              6'd0,  18'h10000, 18'sd131071,  1'b1};
        vecs[8]  = '{-48'sd1073741824,            6'd0,  18'h10000, -18'sd131072, 1'b1};
        vecs[9]  = '{48'h7FFF_FFFF_FFFF,          6'd63, 18'h10000, 18'sd1,       1'b0};
        vecs[10] = '{48'h8000_0000_0000,          6'd50, 18'h10000, -18'sd1,      1'b0};
        vecs[11] = '{48'd0,                       6'd0,  18'h10000, 18'sd0,       1'b0};

        n_in_valid  = 0;
        n_out_valid = 0;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            load_cfg(vecs[i].sh, vecs[i].g, 1'b1);
            cycle(vecs[i].din, 1'b1, 1'b0, 6'd0, 18'd0, 1'b0);
            idle(4);
            check($sformatf("vec%0d_dout", i), longint'(last_dout), longint'(vecs[i].exp_d));
            check($sformatf("vec%0d_sat", i), longint'(bus.satFlag), longint'(vecs[i].exp_sat));
        end

        // Clear racing a saturating sample at the output edge: the set must win.
        load_cfg(6'd0, 18'h10000, 1'b1);
        idle(3);
        check("sat_pre_clear", longint'(bus.satFlag), 0);
        cycle(48'd1073741824, 1'b1, 1'b0, 6'd0, 18'd0, 1'b0);
        idle(2);
        cycle(48'd0, 1'b0, 1'b0, 6'd0, 18'd0, 1'b1);
        check("sat_set_wins", longint'(bus.satFlag), 1);
        cycle(48'd0, 1'b0, 1'b0, 6'd0, 18'd0, 1'b1);
        check("sat_clear_alone", longint'(bus.satFlag), 0);

        // Shift change mid-stream: exactly one clean 4096 -> 256 step.
        load_cfg(6'd0, 18'h10000, 1'b0);
        idle(4);
        obs_q.delete();
        for (int k = 0; k < 6; k++) cycle(48'd4096, 1'b1, 1'b0, 6'd0, 18'd0, 1'b0);
        cycle(48'd4096, 1'b1, 1'b1, 6'd4, 18'h10000, 1'b0);
        for (int k = 0; k < 6; k++) cycle(48'd4096, 1'b1, 1'b0, 6'd0, 18'd0, 1'b0);
        idle(4);
        n_old = 0; n_new = 0; n_bad = 0; n_trans = 0;
        prev = 18'sd4096;
        foreach (obs_q[k]) begin
            if (obs_q[k] == 18'sd4096) n_old++;
            else if (obs_q[k] == 18'sd256) n_new++;
            else n_bad++;
            if (obs_q[k] != prev) n_trans++;
            prev = obs_q[k];
        end
        check("cfg_old_scale_count", n_old, 7);
        check("cfg_new_scale_count", n_new, 6);
        check("cfg_bad_values", n_bad, 0);
        check("cfg_transitions", n_trans, 1);

        // Reset with valid samples in flight, then a gapped valid pattern at default gain.
        load_cfg(6'd0, 18'h08000, 1'b0);
        for (int k = 0; k < 3; k++) cycle(48'd5000, 1'b1, 1'b0, 6'd0, 18'd0, 1'b0);
        do_reset();
        n_in_valid  = 0;
        n_out_valid = 0;
        obs_q.delete();
        for (int k = 0; k < 9; k++) begin
            cycle(48'd1000 + 48'(k), (9'b101001101 >> k) & 9'd1 ? 1'b1 : 1'b0, 1'b0, 6'd0, 18'd0, 1'b0);
        end
        idle(4);
        check("gap_valid_count", n_out_valid, n_in_valid);
        check("gap_first_unity", longint'(obs_q[0]), 1000);

        // Random traffic against the model.
        for (int k = 0; k < 500; k++) begin
            case ($urandom_range(0, 3))
                0: begin
                    tmp = int'($urandom_range(0, 2047)) - 1024;
                    d = 48'(longint'(tmp));
                end
                1: begin
                    tmp = int'($urandom_range(0, 33554431)) - 16777216;
                    d = 48'(longint'(tmp));
                end
                2: d = {$urandom, $urandom} >> $urandom_range(0, 40);
                default: d = 48'({$urandom, $urandom});
            endcase
            rsh = 6'($urandom_range(0, 63));
            rg  = 18'($urandom);
            cycle(d, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rsh, rg,
                  $urandom_range(0, 7) == 0);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
